nts_tx_arbiter: RTL and testbench



---
 rtl/nts_tx_pkg.sv | 34 +++
 rtl/nts_tx_word_fifo.sv | 51 +++++
 rtl/nts_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_nts_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nts_tx_pkg.sv
// Shared types and helpers for the NTS TX arbiter.
// Holds the FSM encoding, the buffered word record and the byte-mask helper.
package nts_tx_pkg;

  localparam int NTS_MAC_WIDTH = 64;
  localparam int NTS_BYTES_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_RELEASE
  } tx_state_e;

  typedef struct packed {
    logic [NTS_MAC_WIDTH-1:0] data;
    logic [7:0]               mask;
    logic                     start;
    logic                     last;
  } tx_word_t;

  // 0 or >8 valid bytes means a full word
  function automatic logic [7:0] bytes_to_mask(
    input logic [NTS_BYTES_W-1:0] n
  );
    logic [7:0] m;
    m = 8'hFF;
    if (n != '0 && n < 4'd8) begin
      m = ~(8'hFF >> n);
    end
    return m;
  endfunction

endpackage

// File: rtl/nts_tx_word_fifo.sv
// Small first-word-fall-through buffer for framed MAC words.
// The head entry is visible on rdata whenever count is non-zero.
module nts_tx_word_fifo
  import nts_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  tx_word_t                 wdata,
  output tx_word_t                 rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  tx_word_t       mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/nts_tx_arbiter.sv
// Round-robin collector of engine TX packets onto one 64-bit MAC stream.
// Frames packets with start/last/byte-mask and cuts overlong ones.
module nts_tx_arbiter
  import nts_tx_pkg::*;
#(
  parameter int ENGINES        = 4,
  parameter int MAC_DATA_WIDTH = 64,
  parameter int BUF_DEPTH      = 4,
  parameter int MAX_WORDS      = 200
) (
  input  logic                              i_clk,
  input  logic                              i_areset_n,
  input  logic [ENGINES-1:0]                i_engine_packet_available,
  output logic [ENGINES-1:0]                o_engine_packet_read,
  input  logic [ENGINES-1:0]                i_engine_fifo_empty,
  output logic [ENGINES-1:0]                o_engine_fifo_rd_en,
  input  logic [MAC_DATA_WIDTH*ENGINES-1:0] i_engine_fifo_rd_data,
  input  logic [NTS_BYTES_W*ENGINES-1:0]    i_engine_bytes_last_word,
  output logic [MAC_DATA_WIDTH-1:0]         o_mac_tx_data,
  output logic [7:0]                        o_mac_tx_data_valid,
  output logic                              o_mac_tx_start,
  output logic                              o_mac_tx_last,
  input  logic                              i_mac_tx_ready,
  output logic                              o_busy,
  output logic                              o_error_truncated,
  output logic [3:0]                        o_grant
);

  localparam int GW = (ENGINES > 1) ? $clog2(ENGINES) : 1;
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int BW = $clog2(BUF_DEPTH);

  tx_state_e               state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           rr_q, rr_d;
  logic [CW-1:0]           wcnt_q, wcnt_d;
  logic                    inflight_q, inflight_d;

  logic [BW:0]             buf_count;
  logic                    buf_valid, push, pop;
  tx_word_t                in_word, head;
  logic                    g_empty, at_max, rd_ok;
  logic [NTS_MAC_WIDTH-1:0] g_data;
  logic [NTS_BYTES_W-1:0]  g_bytes;
  logic [CW:0]             requested;
  logic [GW-1:0]           pick, idx;
  logic [GW:0]             sum;
  logic                    found;

  assign g_empty = i_engine_fifo_empty[grant_q];
  assign g_data  = i_engine_fifo_rd_data[NTS_MAC_WIDTH*grant_q +: NTS_MAC_WIDTH];
  assign g_bytes = i_engine_bytes_last_word[NTS_BYTES_W*grant_q +: NTS_BYTES_W];

  // first requester at or after rr, wrapping
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = ENGINES - 1; i >= 0; i--) begin
      sum = {1'b0, rr_q} + (GW+1)'(i);
      if (sum >= (GW+1)'(ENGINES)) begin
        sum = sum - (GW+1)'(ENGINES);
      end
      idx = sum[GW-1:0];
      if (i_engine_packet_available[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign buf_valid = (buf_count != '0);
  assign pop       = buf_valid && i_mac_tx_ready;
  assign requested = {1'b0, wcnt_q} + (CW+1)'(inflight_q);
  assign at_max    = (wcnt_q == CW'(MAX_WORDS - 1));
  assign rd_ok     = !g_empty
                  && (requested < (CW+1)'(MAX_WORDS))
                  && (({1'b0, buf_count} + (BW+2)'(inflight_q))
                      < (BW+2)'(BUF_DEPTH));

  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    rr_d                 = rr_q;
    wcnt_d               = wcnt_q;
    inflight_d           = 1'b0;
    push                 = 1'b0;
    o_engine_fifo_rd_en  = '0;
    o_engine_packet_read = '0;
    o_error_truncated    = 1'b0;
    in_word.data         = g_data;
    in_word.mask         = 8'hFF;
    in_word.start        = (wcnt_q == '0);
    in_word.last         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = pick;
          wcnt_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (inflight_q) begin
          push   = 1'b1;
          wcnt_d = wcnt_q + CW'(1);
          if (g_empty) begin
            in_word.last = 1'b1;
            in_word.mask = bytes_to_mask(g_bytes);
            state_d      = ST_DRAIN;
          end else if (at_max) begin
            in_word.last      = 1'b1;
            o_error_truncated = 1'b1;
            state_d           = ST_DRAIN;
          end
        end
        if (rd_ok) begin
          o_engine_fifo_rd_en[grant_q] = 1'b1;
          inflight_d                   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!buf_valid) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        o_engine_packet_read[grant_q] = 1'b1;
        rr_d    = (grant_q == GW'(ENGINES - 1)) ? '0 : grant_q + GW'(1);
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      wcnt_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      wcnt_q     <= wcnt_d;
      inflight_q <= inflight_d;
    end
  end

  nts_tx_word_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (i_clk),
    .rst_n (i_areset_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_word),
    .rdata (head),
    .count (buf_count)
  );

  assign o_mac_tx_data       = buf_valid ? head.data : '0;
  assign o_mac_tx_data_valid = buf_valid ? head.mask : 8'h00;
  assign o_mac_tx_start      = buf_valid && head.start;
  assign o_mac_tx_last       = buf_valid && head.last;
  assign o_busy              = (state_q != ST_IDLE);
  assign o_grant             = 4'(grant_q);

endmodule

// File: tb/tb_nts_tx_arbiter.sv
// Bench for nts_tx_arbiter: engine FIFO models, MAC-side scoreboard,
// table of single-packet cases and hand-written multi-cycle sequences.
module tb_nts_tx_arbiter;
  import nts_tx_pkg::*;

  localparam int NE    = 4;
  localparam int DEPTH = 4;
  localparam int MAXW  = 200;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  mask;
    logic        start;
    logic        last;
  } exp_t;

  typedef struct {
    int         eng;
    int         len;
    int         nbytes;
    logic [7:0] last_mask;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NE-1:0]   avail = '0;
  logic [NE-1:0]   empty = '1;
  logic [NE-1:0]   pkt_read, rd_en;
  logic [64*NE-1:0] rd_data = '0;
  logic [4*NE-1:0] nbytes_in = '0;
  logic [63:0]     tx_data;
  logic [7:0]      tx_valid;
  logic            tx_start, tx_last;
  logic            ready = 1'b1;
  logic            busy, trunc;
  logic [3:0]      grant;

  logic [63:0] eq [NE][$];
  exp_t        exp_q[$];
  int          rel_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_total = 0;
  int   rd_total = 0;
  int   pr_total = 0;
  int   trunc_total = 0;
  int   first_acc_cyc = -1;
  logic prev_hold = 1'b0;
  exp_t prev_out = '0;

  always #5 clk = ~clk;

  nts_tx_arbiter #(
    .ENGINES        (NE),
    .MAC_DATA_WIDTH (64),
    .BUF_DEPTH      (DEPTH),
    .MAX_WORDS      (MAXW)
  ) dut (
    .i_clk                     (clk),
    .i_areset_n                (rst_n),
    .i_engine_packet_available (avail),
    .o_engine_packet_read      (pkt_read),
    .i_engine_fifo_empty       (empty),
    .o_engine_fifo_rd_en       (rd_en),
    .i_engine_fifo_rd_data     (rd_data),
    .i_engine_bytes_last_word  (nbytes_in),
    .o_mac_tx_data             (tx_data),
    .o_mac_tx_data_valid       (tx_valid),
    .o_mac_tx_start            (tx_start),
    .o_mac_tx_last             (tx_last),
    .i_mac_tx_ready            (ready),
    .o_busy                    (busy),
    .o_error_truncated         (trunc),
    .o_grant                   (grant)
  );

  function automatic void chk(string name, logic [127:0] act,
                              logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic logic [63:0] mkw(int e, int t, int i);
    return {8'(e), 8'(t), 16'hA5C3, 32'(i)};
  endfunction

  // one clock: sample before the edge, update engine models after it
  task automatic step();
    exp_t          cur, e;
    int            n, r;
    logic [NE-1:0] rd_s, pr_s;
    @(negedge clk);
    cur = {tx_data, tx_valid, tx_start, tx_last};
    if (prev_hold) chk("hold_stable", 128'(cur), 128'(prev_out));
    rd_s = rd_en;
    pr_s = pkt_read;
    if (rd_s != '0) begin
      n = rd_total - acc_total;
      chk("rd_room", 128'(n < DEPTH), 128'(1));
      rd_total++;
    end
    if (tx_valid != 8'h00 && ready) begin
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      chk("sb_has_entry", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_word", 128'(cur), 128'(e));
      end
      acc_total++;
    end
    if (trunc) trunc_total++;
    if (pr_s != '0) begin
      pr_total++;
      chk("rel_has_entry", 128'(rel_q.size() != 0), 128'(1));
      if (rel_q.size() != 0) begin
        r = rel_q.pop_front();
        chk("rel_engine", 128'(pr_s), 128'(1) << r);
      end
    end
    prev_hold = (tx_valid != 8'h00) && !ready;
    prev_out  = cur;
    @(posedge clk);
    #1;
    for (int k = 0; k < NE; k++) begin
      if (rd_s[k]) begin
        if (eq[k].size() != 0) rd_data[64*k +: 64] = eq[k].pop_front();
        empty[k] = (eq[k].size() == 0);
      end
      if (pr_s[k]) begin
        eq[k].delete();
        avail[k] = 1'b0;
        empty[k] = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic load(int eng, int len, int nb, int tag);
    for (int i = 0; i < len; i++) eq[eng].push_back(mkw(eng, tag, i));
    nbytes_in[4*eng +: 4] = 4'(nb);
    empty[eng] = 1'b0;
    avail[eng] = 1'b1;
  endtask

  task automatic expect_pkt(int eng, int n, logic [7:0] lm, int tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data  = mkw(eng, tag, i);
      e.mask  = (i == n - 1) ? lm : 8'hFF;
      e.start = (i == 0);
      e.last  = (i == n - 1);
      exp_q.push_back(e);
    end
    rel_q.push_back(eng);
  endtask

  task automatic wait_rel(int target, int budget, string name);
    int n;
    n = 0;
    while (pr_total < target && n < budget) begin
      step();
      n++;
    end
    chk(name, 128'(pr_total >= target), 128'(1));
  endtask

  initial begin
    vec_t tbl [5];
    int   base, a0, t0, p0, n;
    exp_t e;

    tbl[0] = '{0, 3, 8, 8'hFF};
    tbl[1] = '{1, 2, 3, 8'hE0};
    tbl[2] = '{3, 1, 0, 8'hFF};
    tbl[3] = '{2, 4, 5, 8'hF8};
    tbl[4] = '{0, 1, 9, 8'hFF};

    repeat (2) step();
    chk("reset_outs", 128'({pkt_read, rd_en, tx_data, tx_valid, tx_start,
                            tx_last, busy, trunc, grant}), 128'(0));
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 128'({busy, grant}), 128'(0));

    // engines 0 and 2 together, then 0 and 1 while 2 still waits
    load(0, 2, 8, 10);
    load(2, 3, 8, 12);
    expect_pkt(0, 2, 8'hFF, 10);
    expect_pkt(1, 2, 8'hC0, 11);
    expect_pkt(2, 3, 8'hFF, 12);
    expect_pkt(0, 1, 8'hFF, 13);
    step();
    step();
    chk("rr_busy", 128'(busy), 128'(1));
    chk("rr_grant0", 128'(grant), 128'(0));
    wait_rel(pr_total + 1, 100, "rr_first_release");
    load(0, 1, 8, 13);
    load(1, 2, 2, 11);
    wait_rel(pr_total + 3, 300, "rr_rest_release");
    chk("rr_sb_empty", 128'(exp_q.size()), 128'(0));

    foreach (tbl[v]) begin
      base = cyc;
      first_acc_cyc = -1;
      load(tbl[v].eng, tbl[v].len, tbl[v].nbytes, v);
      expect_pkt(tbl[v].eng, tbl[v].len, tbl[v].last_mask, v);
      wait_rel(pr_total + 1, 100, "tbl_release");
      chk("tbl_latency", 128'(first_acc_cyc - base), 128'(3));
      chk("tbl_sb_empty", 128'(exp_q.size()), 128'(0));
    end

    // backpressure in the middle of a 12-word packet
    load(3, 12, 6, 40);
    expect_pkt(3, 12, 8'hFC, 40);
    a0 = acc_total;
    n = 0;
    while (acc_total < a0 + 2 && n < 50) begin
      step();
      n++;
    end
    chk("bp_started", 128'(acc_total - a0), 128'(2));
    ready = 1'b0;
    repeat (10) step();
    chk("bp_no_rd_when_full", 128'(rd_en), 128'(0));
    chk("bp_word_presented", 128'(tx_valid != 8'h00), 128'(1));
    chk("bp_no_accept", 128'(acc_total - a0), 128'(2));
    ready = 1'b1;
    wait_rel(pr_total + 1, 200, "bp_release");
    chk("bp_sb_empty", 128'(exp_q.size()), 128'(0));

    // overlong packet is cut at MAXW words
    t0 = trunc_total;
    a0 = acc_total;
    load(1, 250, 3, 50);
    expect_pkt(1, MAXW, 8'hFF, 50);
    wait_rel(pr_total + 1, 2000, "trunc_release");
    chk("trunc_pulse_once", 128'(trunc_total - t0), 128'(1));
    chk("trunc_word_count", 128'(acc_total - a0), 128'(MAXW));
    chk("trunc_sb_empty", 128'(exp_q.size()), 128'(0));

    // reset while the second word of a packet is on the MAC
    load(2, 4, 8, 60);
    e.data  = mkw(2, 60, 0);
    e.mask  = 8'hFF;
    e.start = 1'b1;
    e.last  = 1'b0;
    exp_q.push_back(e);
    a0 = acc_total;
    n = 0;
    while (acc_total < a0 + 1 && n < 50) begin
      step();
      n++;
    end
    chk("rst_first_word", 128'(acc_total - a0), 128'(1));
    chk("rst_second_shown", 128'(tx_valid != 8'h00), 128'(1));
    p0 = pr_total;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 128'({pkt_read, rd_en, tx_data, tx_valid, tx_start,
                              tx_last, busy, trunc, grant}), 128'(0));
    step();
    eq[2].delete();
    avail[2] = 1'b0;
    empty[2] = 1'b1;
    rd_total = acc_total;
    prev_hold = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst_no_release", 128'(pr_total - p0), 128'(0));
    chk("rst_idle", 128'({busy, grant}), 128'(0));
    load(3, 2, 8, 71);
    load(0, 2, 8, 70);
    expect_pkt(0, 2, 8'hFF, 70);
    expect_pkt(3, 2, 8'hFF, 71);
    wait_rel(pr_total + 2, 200, "rst_rr_release");
    chk("final_sb_empty", 128'(exp_q.size()), 128'(0));
    chk("final_rel_empty", 128'(rel_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
